// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Purpose:
//   Sequential instruction fetcher feeding the decode stage. It issues
//   word-aligned fetch requests to a pipelined instruction memory and buffers
//   the returned words, tagged with their addresses, in a small prefetch FIFO.
//   A redirect (branch or exception) flushes the FIFO, restarts fetch at the
//   new PC and silently discards responses still in flight.
//
// Bit numbering:
//   The external documentation numbers bits big-endian ([0:31], bit 0 = MSB).
//   Here every vector is [31:0] with bit 31 = MSB, so the documented bits
//   30:31 are the bits [1:0] used below.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   mem_req_valid/ready fetch request handshake, mem_req_addr = fetch PC
//   mem_resp_valid/data in-order response words, no backpressure
//   redirect_valid/addr one-cycle restart pulse, low 2 address bits ignored
//   instruction_valid/ready/instruction/instruction_addr  FIFO head to decode
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0100,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    output logic        instruction_valid,
    input  logic        instruction_ready,
    output logic [31:0] instruction,
    output logic [31:0] instruction_addr
);

    localparam int          CW      = $clog2(FIFO_DEPTH + 1);
    localparam int          PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

    // Architectural state
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q,  resp_pc_d;   // address of the next kept response
    logic [31:0]   data_q [FIFO_DEPTH];
    logic [31:0]   addr_q [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q,   count_d;
    logic [CW-1:0] outst_q,   outst_d;      // requests issued, response not yet seen
    logic [CW-1:0] discard_q, discard_d;    // subset of outst_q to be dropped

    logic          credit_ok;
    logic          req_fire;
    logic          resp_take;
    logic          push;
    logic          pop;
    logic [31:0]   redirect_pc;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Masking keeps every redirect_addr bit in use while forcing alignment.
    assign redirect_pc = redirect_addr & 32'hFFFF_FFFC;

    // Credit: every in-flight request (including ones that will be discarded)
    // reserves a FIFO slot, so responses can always be absorbed.
    assign credit_ok = ({1'b0, count_q} + {1'b0, outst_q}) < DEPTH_W;

    // Valids are gated by rst so they drop in the very cycle reset asserts.
    assign mem_req_valid     = rst && !redirect_valid && credit_ok;
    assign mem_req_addr      = fetch_pc_q;
    assign instruction_valid = rst && !redirect_valid && (count_q != '0);
    assign instruction       = data_q[rd_ptr_q];
    assign instruction_addr  = addr_q[rd_ptr_q];

    assign req_fire  = mem_req_valid && mem_req_ready;
    // A response with nothing outstanding is stray (e.g. left over from before
    // a reset) and must not disturb any counter.
    assign resp_take = mem_resp_valid && (outst_q != '0);
    assign push      = resp_take && (discard_q == '0) && !redirect_valid;
    assign pop       = instruction_valid && instruction_ready;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        discard_d  = discard_q;
        outst_d    = outst_q + CW'(req_fire) - CW'(resp_take);

        if (redirect_valid) begin
            // No request or pop can happen this cycle; whatever is still
            // outstanding after this cycle's response belongs to the old path.
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            discard_d  = outst_d;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (resp_take && (discard_q != '0)) begin
                discard_d = discard_q - CW'(1);
            end
            if (push) begin
                resp_pc_d = resp_pc_q + 32'd4;
                wr_ptr_d  = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_ADDR;
            resp_pc_q  <= RESET_ADDR;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            outst_q    <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
        end
    end

    // Storage is cleared on reset so the head outputs read zero out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_q[i] <= '0;
                addr_q[i] <= '0;
            end
        end else if (push) begin
            data_q[wr_ptr_q] <= mem_resp_data;
            addr_q[wr_ptr_q] <= resp_pc_q;
        end
    end

endmodule
